// File: rtl/coin_input_conditioner.sv
// Coin button conditioner: synchronize, debounce, detect presses and
// emit one-hot coin pulses with a post-accept lockout window.
module coin_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned LOCKOUT_CYCLES  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] coin_btn,
   output logic [2:0] coin,
   output logic       reject,
   output logic       busy,
   output logic [7:0] coin_count
);

   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      LOCKOUT
   } state_t;

   logic [2:0]      sync1_q, sync2_q;
   logic [2:0]      deb_q, deb_d;
   logic [2:0][7:0] cnt_q, cnt_d;
   logic [2:0]      press_q, press_d;
   state_t          state_q, state_d;
   logic [7:0]      lock_q, lock_d;
   logic [2:0]      coin_q, coin_d;
   logic            reject_q, reject_d;
   logic            busy_q, busy_d;
   logic [7:0]      count_q, count_d;

   // A press is the debounced 0->1 transition, flagged on the same edge.
   always_comb begin
      deb_d   = deb_q;
      cnt_d   = '0;
      press_d = '0;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i]   = sync2_q[i];
               press_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      lock_d   = lock_q;
      coin_d   = '0;
      reject_d = 1'b0;
      count_d  = count_q;
      unique case (state_q)
         IDLE: begin
            if (press_q != '0) begin
               if ($onehot(press_q)) begin
                  state_d = EMIT;
                  coin_d  = press_q;
                  count_d = count_q + 8'd1;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end
         EMIT: begin
            if (LOCKOUT_CYCLES == 0) begin
               state_d = IDLE;
            end else begin
               state_d = LOCKOUT;
               lock_d  = 8'(LOCKOUT_CYCLES);
            end
         end
         LOCKOUT: begin
            lock_d = lock_q - 8'd1;
            if (lock_q <= 8'd1) begin
               state_d = IDLE;
               lock_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            lock_d  = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         deb_q    <= '0;
         cnt_q    <= '0;
         press_q  <= '0;
         state_q  <= IDLE;
         lock_q   <= '0;
         coin_q   <= '0;
         reject_q <= 1'b0;
         busy_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         sync1_q  <= coin_btn;
         sync2_q  <= sync1_q;
         deb_q    <= deb_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
         state_q  <= state_d;
         lock_q   <= lock_d;
         coin_q   <= coin_d;
         reject_q <= reject_d;
         busy_q   <= busy_d;
         count_q  <= count_d;
      end
   end

   assign coin       = coin_q;
   assign reject     = reject_q;
   assign busy       = busy_q;
   assign coin_count = count_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Bench for coin_input_conditioner: per-cycle reference model plus
// directed scenarios with hand-computed edge numbers and counts.
module tb_coin_input_conditioner;

   localparam int D = 4;
   localparam int L = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] coin_btn = 3'b000;
   logic [2:0] coin;
   logic       reject;
   logic       busy;
   logic [7:0] coin_count;

   coin_input_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .LOCKOUT_CYCLES (L)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .coin_btn  (coin_btn),
      .coin      (coin),
      .reject    (reject),
      .busy      (busy),
      .coin_count(coin_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: raw input seen two edges late, a run length of
   // disagreeing samples flips the clean value, and an accepted coin
   // makes the unit busy for 1+L edges during which presses are lost.
   logic [2:0] m_s1, m_s2, m_deb, m_ev, e_coin;
   int         run[3];
   int         m_left, m_count;
   bit         e_rej, e_busy;

   always @(posedge clk) begin
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_deb = 0; m_ev = 0;
         for (int b = 0; b < 3; b++) run[b] = 0;
         m_left = 0; m_count = 0; e_coin = 0; e_rej = 0;
      end else begin
         e_coin = 0;
         e_rej  = 0;
         if (m_left > 0) begin
            m_left--;
         end else if ($countones(m_ev) == 1) begin
            e_coin  = m_ev;
            m_count = (m_count + 1) % 256;
            m_left  = 1 + L;
         end else if ($countones(m_ev) > 1) begin
            e_rej = 1;
         end
         m_ev = 0;
         for (int b = 0; b < 3; b++) begin
            if (m_s2[b] == m_deb[b]) begin
               run[b] = 0;
            end else begin
               run[b]++;
               if (run[b] == D) begin
                  m_deb[b] = m_s2[b];
                  run[b]   = 0;
                  if (m_deb[b]) m_ev[b] = 1'b1;
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = coin_btn;
      end
      e_busy = (m_left > 0);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("coin", int'(coin), int'(e_coin));
         chk("reject", int'(reject), int'(e_rej));
         chk("busy", int'(busy), int'(e_busy));
         chk("coin_count", int'(coin_count), m_count);
      end
   end

   int e, pulses, rejects, first_coin, first_rej, busy_n;
   logic [2:0] last_coin;

   task automatic clear_obs();
      e = 0; pulses = 0; rejects = 0;
      first_coin = 0; first_rej = 0; busy_n = 0;
      last_coin = 0;
   endtask

   task automatic run_n(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
         e++;
         if (coin != 0) begin
            pulses++;
            if (first_coin == 0) first_coin = e;
            last_coin = coin;
         end
         if (reject) begin
            rejects++;
            if (first_rej == 0) first_rej = e;
         end
         if (busy) busy_n++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run_n(1);
      reset = 1'b0;
   endtask

   initial begin
      run_n(1);
      chk_en = 1'b1;
      run_n(1);
      chk("rst_coin", int'(coin), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(coin_count), 0);
      reset = 1'b0;

      // Nickel held 20 cycles
      clear_obs();
      coin_btn = 3'b001;
      run_n(20);
      chk("nickel_edge", first_coin, 7);
      chk("nickel_pulses", pulses, 1);
      chk("nickel_val", int'(last_coin), 1);
      chk("nickel_count", int'(coin_count), 1);
      chk("nickel_busy", busy_n, 5);
      coin_btn = 3'b000;
      run_n(12);

      // Dime glitch, 3 cycles
      do_reset();
      clear_obs();
      coin_btn = 3'b010;
      run_n(3);
      coin_btn = 3'b000;
      run_n(15);
      chk("glitch_pulses", pulses, 0);
      chk("glitch_rej", rejects, 0);
      chk("glitch_count", int'(coin_count), 0);

      // Dime + quarter together
      do_reset();
      clear_obs();
      coin_btn = 3'b110;
      run_n(20);
      chk("dual_rej_edge", first_rej, 7);
      chk("dual_rejects", rejects, 1);
      chk("dual_pulses", pulses, 0);
      chk("dual_count", int'(coin_count), 0);
      coin_btn = 3'b000;
      run_n(12);

      // Quarter, then nickel whose press lands in lockout (edge 9)
      do_reset();
      clear_obs();
      coin_btn = 3'b100;
      run_n(3);
      coin_btn = 3'b101;
      run_n(25);
      chk("lock_pulses", pulses, 1);
      chk("lock_val", int'(last_coin), 4);
      chk("lock_rej", rejects, 0);
      chk("lock_count", int'(coin_count), 1);
      coin_btn = 3'b000;
      run_n(12);

      // Reset on edge 4 of a held quarter
      do_reset();
      clear_obs();
      coin_btn = 3'b100;
      run_n(3);
      chk("mid_pre_pulses", pulses, 0);
      do_reset();
      clear_obs();
      run_n(12);
      chk("mid_edge", first_coin, 7);
      chk("mid_pulses", pulses, 1);
      chk("mid_val", int'(last_coin), 4);
      chk("mid_count", int'(coin_count), 1);
      coin_btn = 3'b000;
      run_n(12);

      // Reset during lockout aborts the sequence
      do_reset();
      clear_obs();
      coin_btn = 3'b100;
      run_n(8);
      coin_btn = 3'b000;
      do_reset();
      chk("abort_busy", int'(busy), 0);
      clear_obs();
      run_n(20);
      chk("abort_pulses", pulses, 0);
      chk("abort_count", int'(coin_count), 0);

      // 256 clean nickel presses wrap the counter
      do_reset();
      clear_obs();
      for (int p = 0; p < 256; p++) begin
         coin_btn = 3'b001;
         run_n(8);
         coin_btn = 3'b000;
         run_n(12);
         if (p == 254) chk("wrap_255", int'(coin_count), 255);
      end
      chk("wrap_pulses", pulses, 256);
      chk("wrap_count", int'(coin_count), 0);
      chk("wrap_rej", rejects, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/coin_input_conditioner.md
COIN_INPUT_CONDITIONER -- requirements
Module: coin_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive cycles a synchronized input must differ from its debounced value before that value changes; legal range 1..255.
REQ-002 Parameter LOCKOUT_CYCLES, default 4: number of cycles after an accepted coin during which new press events are discarded; legal range 0..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 coin_btn  input  3  raw asynchronous coin buttons: bit0 nickel, bit1 dime, bit2 quarter.
REQ-006 coin  output  3  one-hot coin pulse to the vending machine stage (001 nickel, 010 dime, 100 quarter, 000 none); registered.
REQ-007 reject  output  1  one-cycle pulse flagging an ambiguous, discarded simultaneous press; registered.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE; registered.
REQ-009 coin_count  output  8  total coins accepted since reset, unsigned, wraps 255 -> 0.

Function
REQ-010 Each coin_btn bit SHALL pass through a 2-flip-flop synchronizer before any other logic uses it.
REQ-011 Per bit, a debounce counter SHALL clear on any cycle where the synchronized value equals the debounced value, and increment otherwise.
REQ-012 When a debounce counter would reach DEBOUNCE_CYCLES, the debounced value SHALL take the synchronized value on that edge and the counter SHALL clear.
REQ-013 A press event for a bit SHALL be registered on the same edge its debounced value changes 0 -> 1; release (1 -> 0) SHALL generate no event.
REQ-014 The FSM SHALL have the states IDLE, EMIT and LOCKOUT.
REQ-015 IDLE, exactly one press event present: go to EMIT; coin = that one-hot value for exactly one cycle; coin_count increments.
REQ-016 IDLE, two or more press events on the same edge: stay in IDLE; reject = 1 for one cycle; coin stays 000; coin_count unchanged.
REQ-017 EMIT -> LOCKOUT with a lockout counter loaded to LOCKOUT_CYCLES; if LOCKOUT_CYCLES = 0, EMIT -> IDLE directly.
REQ-018 LOCKOUT SHALL last exactly LOCKOUT_CYCLES cycles, then return to IDLE.
REQ-019 Press events arriving in EMIT or LOCKOUT SHALL be dropped silently: no coin, no reject, no deferred replay.
REQ-020 Latency: with a raw input held steady, coin SHALL be asserted on the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples coin_btn high as edge 1.
REQ-021 Apart from the cycle following an EMIT entry, coin SHALL be 000; coin SHALL never have more than one bit set.
REQ-022 A button held indefinitely SHALL produce exactly one coin pulse; a new pulse requires a debounced release and a new press.
REQ-023 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL have no effect on any output.

Reset
REQ-024 While reset is high at a clock edge, the following SHALL be cleared: synchronizers, debounced values, debounce counters, registered press events and the lockout counter; the FSM SHALL go to IDLE; coin = 000, reject = 0, busy = 0, coin_count = 0.
REQ-025 A button already held when reset deasserts SHALL be debounced from 0 and SHALL produce one coin pulse per REQ-020, timed from the first post-reset edge.
REQ-026 Reset asserted during EMIT or LOCKOUT SHALL abort the sequence on that edge, with no further pulse.

Verification
REQ-027 The bench SHALL cover the following scenario (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=4): nickel held 20 cycles -> coin = 001 for one cycle on edge 7; coin_count = 1; busy high for 5 cycles.
REQ-028 The bench SHALL cover the following scenario: dime pulse 3 cycles wide -> coin stays 000, reject stays 0, coin_count stays 0.
REQ-029 The bench SHALL cover the following scenario: dime and quarter raised on the same edge and held -> reject = 1 for one cycle on edge 7; coin stays 000; coin_count unchanged.
REQ-030 The bench SHALL cover the following scenario: quarter accepted, then nickel raised so its event lands in LOCKOUT -> only coin = 100 is seen; coin_count = 1.
REQ-031 The bench SHALL cover the following scenario: reset pulsed mid-debounce (edge 4 of a quarter press), button still held -> no pulse before the reset, then one coin = 100 on post-reset edge 7.
REQ-032 The bench SHALL cover the following scenario: 256 clean nickel presses -> coin_count wraps to 0, and exactly 256 coin pulses are seen.
